// File: rtl/tail_light_input_conditioner.sv
// Input front end for the tail-light sequencer: synchronizes and debounces the
// five driver switches, then resolves them into a registered lamp mode.
module tail_light_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       brake,
  input  logic       hazard,
  input  logic       run,
  output logic       left_q,
  output logic       right_q,
  output logic       brake_q,
  output logic       hazard_q,
  output logic       run_q,
  output logic [2:0] mode,
  output logic       mode_change
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [2:0] MODE_IDLE         = 3'd0;
  localparam logic [2:0] MODE_LEFT         = 3'd1;
  localparam logic [2:0] MODE_RIGHT        = 3'd2;
  localparam logic [2:0] MODE_HAZARD       = 3'd3;
  localparam logic [2:0] MODE_BRAKE        = 3'd4;
  localparam logic [2:0] MODE_BRAKE_LEFT   = 3'd5;
  localparam logic [2:0] MODE_BRAKE_RIGHT  = 3'd6;
  localparam logic [2:0] MODE_BRAKE_HAZARD = 3'd7;

  // Channel order: 0 left, 1 right, 2 brake, 3 hazard, 4 run
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   q;
  logic [CNT_W-1:0] cnt [NCH];

  assign raw = {run, hazard, brake, right, left};

  // A return of s2 to q clears the count, so only an unbroken run of
  // DB_CYCLES mismatching samples flips q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      q  <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          q[i]   <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign left_q   = q[0];
  assign right_q  = q[1];
  assign brake_q  = q[2];
  assign hazard_q = q[3];
  assign run_q    = q[4];

  logic       hz;
  logic [2:0] mode_next;

  assign hz = hazard_q | (left_q & right_q);

  always_comb begin
    mode_next = MODE_IDLE;
    if (hz && brake_q)            mode_next = MODE_BRAKE_HAZARD;
    else if (hz)                  mode_next = MODE_HAZARD;
    else if (brake_q && left_q)   mode_next = MODE_BRAKE_LEFT;
    else if (brake_q && right_q)  mode_next = MODE_BRAKE_RIGHT;
    else if (brake_q)             mode_next = MODE_BRAKE;
    else if (left_q)              mode_next = MODE_LEFT;
    else if (right_q)             mode_next = MODE_RIGHT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode        <= MODE_IDLE;
      mode_change <= 1'b0;
    end else begin
      mode        <= mode_next;
      mode_change <= (mode_next != mode);
    end
  end

endmodule

// File: doc/tail_light_input_conditioner.md
# tail_light_input_conditioner

Front-end stage for the Thunderbird tail-light controller. It samples the five raw driver switches (left, right, brake, hazard, run), synchronizes and debounces each one, and resolves them into a registered 3-bit lamp mode with a one-cycle change strobe. The sequencer stage consumes these clean outputs in place of the raw switches. One clock domain; the sequencer runs on the same `clk`.

## Interface
- `DB_CYCLES`, default 4: consecutive cycles a synchronized input must differ from its debounced value before the debounced value flips; legal range 1..255.
- `CNT_W`, default 8: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `left`, `right`, `brake`, `hazard`, `run`  in  1 each  raw switch inputs, asynchronous to `clk`.
- `left_q`, `right_q`, `brake_q`, `hazard_q`, `run_q`  out  1 each  debounced switch levels.
- `mode`  out  3  registered lamp mode (encoding below).
- `mode_change`  out  1  high for exactly one cycle after each edge where `mode` takes a new value.

## Operation
- Per input, a 2-flop synchronizer (s1, s2), a debounce counter `cnt`, and a debounced flop `q`.
- Per input, each rising edge:
  - s2 == q: cnt <= 0.
  - s2 != q and cnt == DB_CYCLES-1: q <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- A glitch shorter than DB_CYCLES synchronized cycles never reaches `q`. Any return of s2 to q clears cnt, so there is no partial credit.
- Mode decode is combinational from the `*_q` values. `mode` registers the decode result every cycle. Priority order:
  - hz = hazard_q | (left_q & right_q).
  - hz & brake_q -> 7 BRAKE_HAZARD.
  - hz -> 3 HAZARD.
  - brake_q & left_q -> 5 BRAKE_LEFT.
  - brake_q & right_q -> 6 BRAKE_RIGHT.
  - brake_q -> 4 BRAKE.
  - left_q -> 1 LEFT.
  - right_q -> 2 RIGHT.
  - Else -> 0 IDLE.
- `run_q` does not affect `mode`. The sequencer uses it only for dim running lights.
- `mode_change` <= (next decoded mode != current `mode`). It is registered in the same edge that updates `mode`, so both move together.
- Simultaneous input changes: each channel debounces independently. If channels settle on different edges, `mode` may pass through intermediate values, each producing its own `mode_change` pulse. This is intended behaviour.

## Timing
- Reset (rst low): asynchronously clears all s1/s2/q flops, all counters, `mode` = 0, `mode_change` = 0. All outputs read 0 during reset.
- Reset release: the first active edge is the first edge with rst high. Inputs already high at release go through the full latency below and are not bypassed.
- Latency: a raw input is stable from before edge k, with k being the first sampling edge.
  - s2 changes at edge k+1.
  - `*_q` changes at edge k+DB_CYCLES+1.
  - `mode` and `mode_change` change at edge k+DB_CYCLES+2.
  - With DB_CYCLES=4: q at k+5, mode at k+6.
- DB_CYCLES=1: q follows s2 one edge after the mismatch appears, giving q at k+2 and mode at k+3.
- Reset asserted mid-debounce: the count is lost and `mode` returns to 0 immediately. `mode_change` does not pulse on reset entry or exit.
- No handshake. Outputs are level-valid every cycle, and consumers sample on `clk`.

## Test plan
- Reset then `left`=1, held (DB_CYCLES=4): `left_q` rises at k+5; `mode`=1 and `mode_change`=1 at k+6; `mode_change`=0 at k+7.
- `right` pulse 3 cycles wide, then low: `right_q`, `mode`, `mode_change` stay 0 throughout. Repeat with a 4-cycle pulse: `right_q` high for 4 cycles, `mode` 0→2→0, two `mode_change` pulses.
- Holding `brake`=1, raise `left`=1: mode 4→5. Then raise `right`=1: mode →7. Then drop `brake`: mode →3. Each step produces exactly one `mode_change` pulse.
- `hazard`=1 and `run`=1 together: `mode`=3, `run_q`=1. Then toggle `run` only: `run_q` follows after DB_CYCLES+1; `mode` unchanged and no `mode_change` pulse.
- `brake`+`right` settled (mode 6), then pull `rst` low between clock edges: all outputs 0 before the next edge. Release `rst` with inputs still high: mode returns to 6 at release edge + 6, with one `mode_change` pulse.
- Bouncing `hazard`: 1,0,1,1,0,1,1,1,1 on successive cycles then held high: `hazard_q` rises only after the final 4-cycle run, with no spurious `mode_change` pulses.
